// File: rtl/instr_cache_pkg.sv
// Shared constants, FSM state type and address field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W     = 10;
  localparam int TAG_W      = 3;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 2;
  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;
  localparam int NUM_BLOCKS = 1 << IDX_W;
  localparam int BLK_W      = ADDR_W - 4;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_e;

  // Byte address layout: {tag, index, word offset, byte offset}.
  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W+2 +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[2 +: OFF_W];
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Core-side fetch port and instruction-memory block port of the cache,
// bundled with a view for the cache (slave) and for its environment (master).
interface instr_cache_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0] pc_addr;
  logic              read;
  logic [WORD_W-1:0] instruction;
  logic              busy_wait;
  logic              im_read;
  logic [BLK_W-1:0]  im_addr;
  logic [LINE_W-1:0] im_readdata;
  logic              im_busywait;

  modport slave (
    input  pc_addr, read, im_readdata, im_busywait,
    output instruction, busy_wait, im_read, im_addr
  );

  modport master (
    output pc_addr, read, im_readdata, im_busywait,
    input  instruction, busy_wait, im_read, im_addr
  );

endinterface

// File: rtl/instr_cache_line_array.sv
// Line storage for the instruction cache: data, tag and valid per line,
// combinational read port and one synchronous write port.
module icache_line_array
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i
);

  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: data and tag arrays are never reset; a cleared valid bit is enough
  // to make stale contents unreachable, and it keeps these as plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, and a 4-word
// line fill over the busy_wait handshake on a miss.
module instr_cache
  import icache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  instr_cache_if.slave  bus
);

  state_e            state_q, state_d;
  logic [BLK_W-1:0]  miss_addr_q, miss_addr_d;
  logic              seen_busy_q, seen_busy_d;
  logic [LINE_W-1:0] fill_q, fill_d;

  logic [LINE_W-1:0] rd_line;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              hit;
  logic              busy;
  logic              im_read;
  logic              we;
  logic [ADDR_W-1:0] miss_full;

  assign miss_full = {miss_addr_q, 4'b0000};

  icache_line_array u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (get_index(bus.pc_addr)),
    .rd_data_o  (rd_line),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .we_i       (we && !rst),
    .wr_idx_i   (get_index(miss_full)),
    .wr_tag_i   (get_tag(miss_full)),
    .wr_data_i  (fill_q)
  );

  assign hit = rd_valid && (rd_tag == get_tag(bus.pc_addr));

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    seen_busy_d = seen_busy_q;
    fill_d      = fill_q;
    busy        = 1'b0;
    im_read     = 1'b0;
    we          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.read && !hit) begin
          busy        = 1'b1;
          miss_addr_d = bus.pc_addr[ADDR_W-1:4];
          state_d     = MEM_READ;
        end
      end
      MEM_READ: begin
        busy    = 1'b1;
        im_read = 1'b1;
        // Data is valid only on the falling edge of a busy period we observed.
        if (bus.im_busywait) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          fill_d  = bus.im_readdata;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy        = 1'b1;
        we          = 1'b1;
        seen_busy_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_wait   = busy && !rst;
  assign bus.im_read     = im_read;
  assign bus.im_addr     = miss_addr_q;
  assign bus.instruction = (!rst && state_q == IDLE && bus.read && hit)
                         ? rd_line[int'(get_offset(bus.pc_addr)) * WORD_W +: WORD_W]
                         : '0;

endmodule
